apb5_regbank: RTL and testbench

Parametrised APB5 completer register bank; successor to the fixed 8-bit-address regbank.
Generalises register count, data width and wait-state insertion. Adds byte-strobe writes, read-only registers, PPROT write protection and PSLVERR error signalling.
Sits behind the APB5 VIP in the RAL bench. Also exports every register value to hardware logic.

---
 rtl/apb5_regbank_pkg.sv | 28 ++
 rtl/apb5_regbank_cell.sv | 32 +++
 rtl/apb5_regbank.sv | 171 +++++++++++++++++
 tb/tb_apb5_regbank.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/apb5_regbank_pkg.sv
// Shared types and helpers for the APB5 register bank.
// Covers the FSM state encoding, the byte-lane helpers and the address LSB helper.
package apb5_regbank_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

    localparam int MAX_DATA_W = 32;
    localparam int STRB_W     = MAX_DATA_W / 8;

    function automatic int addr_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    // Callers zero-extend narrower buses to the widest supported width.
    function automatic logic [MAX_DATA_W-1:0] strb_merge(
        input logic [MAX_DATA_W-1:0] old_v,
        input logic [MAX_DATA_W-1:0] wdata,
        input logic [STRB_W-1:0]     strb
    );
        logic [MAX_DATA_W-1:0] r;
        r = old_v;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) r[b*8 +: 8] = wdata[b*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/apb5_regbank_cell.sv
// One read/write register with byte-strobe write enable.
// Latency: a write is visible on q the cycle after the enabling edge; no backpressure.
module apb5_regbank_cell
    import apb5_regbank_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    pclk,
    input  logic                    presetn,
    input  logic                    we,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] strb,
    output logic [DATA_WIDTH-1:0]   q
);

    logic [DATA_WIDTH-1:0] val_q, val_d;

    always_comb begin
        val_d = val_q;
        if (we) begin
            val_d = DATA_WIDTH'(strb_merge(MAX_DATA_W'(val_q), MAX_DATA_W'(wdata), STRB_W'(strb)));
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) val_q <= '0;
        else          val_q <= val_d;
    end

    assign q = val_q;

endmodule

// File: rtl/apb5_regbank.sv
// APB5 completer register bank with RO registers, PPROT write protection and PSLVERR.
// Latency: pready WAIT_STATES+1 cycles after the first penable cycle; psel drop mid-transfer aborts.
module apb5_regbank
    import apb5_regbank_pkg::*;
#(
    parameter int                ADDR_WIDTH  = 8,
    parameter int                DATA_WIDTH  = 32,
    parameter int                NUM_REGS    = 16,
    parameter int                WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK   = '0,
    parameter bit                PROT_CHECK  = 1'b1
) (
    input  logic                           pclk,
    input  logic                           presetn,
    input  logic                           psel,
    input  logic                           penable,
    input  logic                           pwrite,
    input  logic [ADDR_WIDTH-1:0]          paddr,
    input  logic [DATA_WIDTH-1:0]          pwdata,
    input  logic [DATA_WIDTH/8-1:0]        pstrb,
    input  logic [2:0]                     pprot,
    output logic [DATA_WIDTH-1:0]          prdata,
    output logic                           pslverr,
    output logic                           pready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_rdata
);

    localparam int SW  = DATA_WIDTH / 8;
    localparam int LSB = addr_lsb(DATA_WIDTH);

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    wr_q, wr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]           strb_q, strb_d;
    logic                    priv_q, priv_d;
    logic                    pready_q, pready_d;
    logic                    pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;

    logic [31:0]             idx;
    logic                    ro_hit;
    logic [DATA_WIDTH-1:0]   rd_val;
    logic                    err;
    logic                    commit;
    logic                    prot_unused;

    assign prot_unused = ^pprot[2:1];
    assign idx         = 32'(addr_q >> LSB);

    always_comb begin
        rd_val = '0;
        ro_hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == 32'(i)) begin
                ro_hit = RO_MASK[i];
                rd_val = RO_MASK[i] ? hw_rdata[i*DATA_WIDTH +: DATA_WIDTH]
                                    : reg_q[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign err = (idx >= 32'(NUM_REGS))
               | ((addr_q & ADDR_WIDTH'((1 << LSB) - 1)) != '0)
               | (wr_q & ro_hit)
               | (PROT_CHECK & wr_q & ~priv_q)
               | (~wr_q & (strb_q != '0));

    // Completion flops are loaded one edge early so pready itself is registered.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wr_d      = wr_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        priv_d    = priv_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        commit    = 1'b0;
        case (state_q)
            IDLE: begin
                if (psel && !penable) state_d = SETUP;
            end
            SETUP: begin
                if (!psel) begin
                    state_d = IDLE;
                end else begin
                    state_d = ACCESS;
                    cnt_d   = 4'(WAIT_STATES);
                    if (WAIT_STATES == 0) pready_d = 1'b1;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) pready_d = 1'b1;
                end else begin
                    commit  = wr_q & ~err;
                    state_d = (psel && !penable) ? SETUP : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (pready_d) begin
            pslverr_d = err;
            prdata_d  = (err || wr_q) ? '0 : rd_val;
        end
        if (state_d == SETUP) begin
            addr_d  = paddr;
            wr_d    = pwrite;
            wdata_d = pwdata;
            strb_d  = pstrb;
            priv_d  = pprot[0];
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            priv_q    <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            priv_q    <= priv_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    assign pready  = pready_q;
    assign pslverr = pslverr_q;
    assign prdata  = prdata_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        if (RO_MASK[g]) begin : g_ro
            assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = '0;
        end else begin : g_rw
            logic cell_we;
            assign cell_we = commit & (idx == 32'(g));
            apb5_regbank_cell #(.DATA_WIDTH(DATA_WIDTH)) u_cell (
                .pclk    (pclk),
                .presetn (presetn),
                .we      (cell_we),
                .wdata   (wdata_q),
                .strb    (strb_q),
                .q       (reg_q[g*DATA_WIDTH +: DATA_WIDTH])
            );
        end
    end

endmodule

// File: tb/tb_apb5_regbank.sv
// Directed bench for apb5_regbank: one zero-wait instance with an RO register, one three-wait instance.
module tb_apb5_regbank;

    logic         pclk;
    logic         presetn;
    logic         psel0, psel3, penable, pwrite;
    logic [7:0]   paddr;
    logic [31:0]  pwdata;
    logic [3:0]   pstrb;
    logic [2:0]   pprot;
    logic [31:0]  prdata0, prdata3;
    logic         pslverr0, pslverr3, pready0, pready3;
    logic [511:0] reg_q0, reg_q3;
    logic [511:0] hw_rdata;

    int tests_run    = 0;
    int tests_failed = 0;

    apb5_regbank #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_STATES(0),
                   .RO_MASK(16'h0008), .PROT_CHECK(1'b1)) dut0 (
        .pclk(pclk), .presetn(presetn), .psel(psel0), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot), .prdata(prdata0),
        .pslverr(pslverr0), .pready(pready0), .reg_q(reg_q0), .hw_rdata(hw_rdata));

    apb5_regbank #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_STATES(3),
                   .RO_MASK(16'h0000), .PROT_CHECK(1'b1)) dut3 (
        .pclk(pclk), .presetn(presetn), .psel(psel3), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot), .prdata(prdata3),
        .pslverr(pslverr3), .pready(pready3), .reg_q(reg_q3), .hw_rdata(hw_rdata));

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Runs one transfer; cycles counts negedges from the first penable cycle up to pready.
    task automatic apb_xfer(input int which, input logic wr, input logic [7:0] addr,
                            input logic [31:0] data, input logic [3:0] strb, input logic [2:0] prot,
                            output logic [31:0] rdata, output logic slverr,
                            output int cycles, output logic early);
        logic        rdy, e;
        logic [31:0] rd;
        early = 1'b0; cycles = 0; rdata = '0; slverr = 1'b0;
        @(posedge pclk); #1;
        psel0 = (which == 0); psel3 = (which == 3); penable = 1'b0;
        pwrite = wr; paddr = addr; pwdata = data; pstrb = strb; pprot = prot;
        @(posedge pclk); #1;
        penable = 1'b1;
        do begin
            @(negedge pclk);
            cycles++;
            rdy = (which == 0) ? pready0   : pready3;
            e   = (which == 0) ? pslverr0  : pslverr3;
            rd  = (which == 0) ? prdata0   : prdata3;
            if (!rdy && (e || rd != 0)) early = 1'b1;
        end while (!rdy && cycles < 50);
        if (rdy) begin
            rdata  = rd;
            slverr = e;
        end
        @(posedge pclk); #1;
        psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        presetn = 1'b0;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        tests_run++; if (pready0 !== 1'b0) begin tests_failed++; $display("FAIL reset_pready got %b exp 0", pready0); end
        tests_run++; if (pslverr0 !== 1'b0) begin tests_failed++; $display("FAIL reset_pslverr got %b exp 0", pslverr0); end
        tests_run++; if (prdata0 !== 32'h0) begin tests_failed++; $display("FAIL reset_prdata got %h exp 0", prdata0); end
        tests_run++; if (reg_q0 !== 512'h0 || reg_q3 !== 512'h0) begin tests_failed++; $display("FAIL reset_reg_q got nonzero exp 0"); end
        @(posedge pclk); #1;
        presetn = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] rd; logic se, early; int cyc;
        apb_xfer(0, 1'b1, 8'h04, 32'hDEADBEEF, 4'hF, 3'b001, rd, se, cyc, early);
        tests_run++; if (cyc !== 2) begin tests_failed++; $display("FAIL basic_wr_latency got %0d exp 2", cyc); end
        tests_run++; if (se !== 1'b0 || rd !== 32'h0) begin tests_failed++; $display("FAIL basic_wr_resp got err=%b data=%h exp 0/0", se, rd); end
        tests_run++; if (reg_q0[32 +: 32] !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL basic_reg_q got %h exp deadbeef", reg_q0[32 +: 32]); end
        apb_xfer(0, 1'b0, 8'h04, 32'h0, 4'h0, 3'b001, rd, se, cyc, early);
        tests_run++; if (cyc !== 2) begin tests_failed++; $display("FAIL basic_rd_latency got %0d exp 2", cyc); end
        tests_run++; if (rd !== 32'hDEADBEEF || se !== 1'b0) begin tests_failed++; $display("FAIL basic_rd got %h err=%b exp deadbeef/0", rd, se); end
    endtask

    task automatic test_strobe();
        logic [31:0] rd; logic se, early; int cyc;
        apb_xfer(0, 1'b1, 8'h08, 32'h11223344, 4'hF, 3'b001, rd, se, cyc, early);
        apb_xfer(0, 1'b1, 8'h08, 32'hAABBCCDD, 4'h5, 3'b001, rd, se, cyc, early);
        apb_xfer(0, 1'b0, 8'h08, 32'h0, 4'h0, 3'b001, rd, se, cyc, early);
        tests_run++; if (rd !== 32'h11BB33DD) begin tests_failed++; $display("FAIL strobe_read got %h exp 11bb33dd", rd); end
        tests_run++; if (reg_q0[64 +: 32] !== 32'h11BB33DD) begin tests_failed++; $display("FAIL strobe_reg_q got %h exp 11bb33dd", reg_q0[64 +: 32]); end
        apb_xfer(0, 1'b1, 8'h08, 32'h99999999, 4'h0, 3'b001, rd, se, cyc, early);
        tests_run++; if (se !== 1'b0 || reg_q0[64 +: 32] !== 32'h11BB33DD) begin tests_failed++; $display("FAIL strobe_zero got err=%b val=%h exp 0/11bb33dd", se, reg_q0[64 +: 32]); end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd; logic se, early; int cyc;
        apb_xfer(3, 1'b1, 8'h10, 32'h12345678, 4'hF, 3'b001, rd, se, cyc, early);
        tests_run++; if (cyc !== 5 || se !== 1'b0) begin tests_failed++; $display("FAIL wait_wr got cyc=%0d err=%b exp 5/0", cyc, se); end
        apb_xfer(3, 1'b0, 8'h10, 32'h0, 4'h0, 3'b001, rd, se, cyc, early);
        tests_run++; if (cyc !== 5) begin tests_failed++; $display("FAIL wait_rd_latency got %0d exp 5", cyc); end
        tests_run++; if (early !== 1'b0) begin tests_failed++; $display("FAIL wait_rd_early got %b exp 0", early); end
        tests_run++; if (rd !== 32'h12345678) begin tests_failed++; $display("FAIL wait_rd_data got %h exp 12345678", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic se, early; int cyc;
        apb_xfer(0, 1'b1, 8'h40, 32'h0BAD0BAD, 4'hF, 3'b001, rd, se, cyc, early);
        tests_run++; if (se !== 1'b1 || rd !== 32'h0) begin tests_failed++; $display("FAIL err_range got err=%b data=%h exp 1/0", se, rd); end
        apb_xfer(0, 1'b1, 8'h05, 32'h0BAD0BAD, 4'hF, 3'b001, rd, se, cyc, early);
        tests_run++; if (se !== 1'b1) begin tests_failed++; $display("FAIL err_misalign got %b exp 1", se); end
        apb_xfer(0, 1'b1, 8'h04, 32'h0BAD0BAD, 4'hF, 3'b000, rd, se, cyc, early);
        tests_run++; if (se !== 1'b1) begin tests_failed++; $display("FAIL err_prot got %b exp 1", se); end
        apb_xfer(0, 1'b0, 8'h04, 32'h0, 4'h3, 3'b001, rd, se, cyc, early);
        tests_run++; if (se !== 1'b1 || rd !== 32'h0) begin tests_failed++; $display("FAIL err_rd_strb got err=%b data=%h exp 1/0", se, rd); end
        tests_run++; if (reg_q0[32 +: 32] !== 32'hDEADBEEF || reg_q0[0 +: 32] !== 32'h0) begin tests_failed++; $display("FAIL err_no_change got %h/%h exp deadbeef/0", reg_q0[32 +: 32], reg_q0[0 +: 32]); end
    endtask

    task automatic test_read_only();
        logic [31:0] rd; logic se, early; int cyc;
        apb_xfer(0, 1'b0, 8'h0C, 32'h0, 4'h0, 3'b001, rd, se, cyc, early);
        tests_run++; if (rd !== 32'hCAFE0001 || se !== 1'b0) begin tests_failed++; $display("FAIL ro_read got %h err=%b exp cafe0001/0", rd, se); end
        apb_xfer(0, 1'b1, 8'h0C, 32'h00000055, 4'hF, 3'b001, rd, se, cyc, early);
        tests_run++; if (se !== 1'b1) begin tests_failed++; $display("FAIL ro_write_err got %b exp 1", se); end
        apb_xfer(0, 1'b0, 8'h0C, 32'h0, 4'h0, 3'b001, rd, se, cyc, early);
        tests_run++; if (rd !== 32'hCAFE0001) begin tests_failed++; $display("FAIL ro_reread got %h exp cafe0001", rd); end
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic se, early, seen; int cyc;
        seen = 1'b0;
        @(posedge pclk); #1;
        psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h14;
        pwdata = 32'hA5A5A5A5; pstrb = 4'hF; pprot = 3'b001;
        @(posedge pclk); #1 penable = 1'b1;
        @(posedge pclk); #1;
        @(posedge pclk); #1 psel3 = 1'b0; penable = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge pclk);
            if (pready3) seen = 1'b1;
        end
        tests_run++; if (seen !== 1'b0) begin tests_failed++; $display("FAIL abort_pready got %b exp 0", seen); end
        tests_run++; if (reg_q3[160 +: 32] !== 32'h0) begin tests_failed++; $display("FAIL abort_no_write got %h exp 0", reg_q3[160 +: 32]); end
        apb_xfer(3, 1'b0, 8'h14, 32'h0, 4'h0, 3'b001, rd, se, cyc, early);
        tests_run++; if (cyc !== 5 || rd !== 32'h0) begin tests_failed++; $display("FAIL abort_recover got cyc=%0d data=%h exp 5/0", cyc, rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic se, early; int cyc;
        @(posedge pclk); #1;
        psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00;
        pwdata = 32'hFFFFFFFF; pstrb = 4'hF; pprot = 3'b001;
        @(posedge pclk); #1 penable = 1'b1;
        @(negedge pclk);
        presetn = 1'b0;
        @(negedge pclk);
        tests_run++; if (pready0 !== 1'b0) begin tests_failed++; $display("FAIL rstmid_pready got %b exp 0", pready0); end
        psel0 = 1'b0; penable = 1'b0;
        @(posedge pclk); #1 presetn = 1'b1;
        apb_xfer(0, 1'b0, 8'h00, 32'h0, 4'h0, 3'b001, rd, se, cyc, early);
        tests_run++; if (rd !== 32'h0 || se !== 1'b0 || cyc !== 2) begin tests_failed++; $display("FAIL rstmid_read got %h err=%b cyc=%0d exp 0/0/2", rd, se, cyc); end
        tests_run++; if (reg_q0[0 +: 32] !== 32'h0) begin tests_failed++; $display("FAIL rstmid_reg_q got %h exp 0", reg_q0[0 +: 32]); end
    endtask

    initial begin
        psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
        hw_rdata = '0;
        hw_rdata[96 +: 32] = 32'hCAFE0001;
        test_reset();
        test_basic();
        test_strobe();
        test_wait_states();
        test_errors();
        test_read_only();
        test_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
